// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the hazard stall unit and the forwarding logic, so
// both sides apply exactly the same register-match rule.
//   ADDRESS_SIZE  default register index width
//   ZERO_ADDRESS  the hard-wired zero register (never a real producer)
//   stall_state_e stall controller state encoding (RUN=0, STALL=1)
//   reg_hit()     producer/consumer register match
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int ADDRESS_SIZE = 5;

    localparam logic [ADDRESS_SIZE-1:0] ZERO_ADDRESS = {ADDRESS_SIZE{1'b0}};

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    // A write to x0 is discarded by the register file, so it never creates a hazard.
    function automatic logic reg_hit(input logic [ADDRESS_SIZE-1:0] rd,
                                     input logic [ADDRESS_SIZE-1:0] rs);
        return (rd == rs) && (rd != ZERO_ADDRESS);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_if
// Bundles the pipeline-side hazard inputs and the stall/flush controls.
//   master : pipeline side, drives ID/EX/MEM status, receives controls
//   slave  : hazard stall unit side
// -----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
    parameter int AddressSize = 5,
    parameter int CntWidth    = 32
);
    // ID stage
    logic [AddressSize-1:0] IDRs1;
    logic [AddressSize-1:0] IDRs2;
    logic                   idUsesRs1;
    logic                   idUsesRs2;
    logic                   idIsBranch;
    logic                   branchTaken;
    // EX stage
    logic [AddressSize-1:0] EXRegisterRd;
    logic                   regWriteEX;
    logic                   memReadEX;
    // MEM stage
    logic [AddressSize-1:0] MemRegisterRd;
    logic                   memReadMem;
    // Controls back to the pipeline
    logic                   pcWrite;
    logic                   ifidWrite;
    logic                   ifidFlush;
    logic                   idexBubble;
    logic                   stallActive;
    logic [CntWidth-1:0]    stallCycles;

    modport master (
        output IDRs1, IDRs2, idUsesRs1, idUsesRs2, idIsBranch, branchTaken,
        output EXRegisterRd, regWriteEX, memReadEX, MemRegisterRd, memReadMem,
        input  pcWrite, ifidWrite, ifidFlush, idexBubble, stallActive, stallCycles
    );

    modport slave (
        input  IDRs1, IDRs2, idUsesRs1, idUsesRs2, idIsBranch, branchTaken,
        input  EXRegisterRd, regWriteEX, memReadEX, MemRegisterRd, memReadMem,
        output pcWrite, ifidWrite, ifidFlush, idexBubble, stallActive, stallCycles
    );

endinterface

// File: rtl/hazard_stall_unit_perf_counter.sv
// -----------------------------------------------------------------------------
// stall_perf_counter
// Saturating event counter for stall cycles.
//   clk      in  pipeline clock
//   i_clr_n  in  synchronous active-low clear
//   i_inc    in  count one event at this edge
//   o_count  out current count, holds at all-ones once saturated
// -----------------------------------------------------------------------------
module stall_perf_counter #(
    parameter int CntWidth = 32
) (
    input  logic                clk,
    input  logic                i_clr_n,
    input  logic                i_inc,
    output logic [CntWidth-1:0] o_count
);

    logic [CntWidth-1:0] r_count;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= {CntWidth{1'b0}};
        end else if (i_inc && (r_count != {CntWidth{1'b1}})) begin
            r_count <= r_count + CntWidth'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Stall/flush controller for the 5-stage pipeline. Covers the hazards the
// bypass network cannot: load-use into EX, and any producer feeding a branch
// compared in ID (the ID comparator only sees the MEM ALU result).
//   clk     in  pipeline clock
//   arst_n  in  synchronous active-low reset (sampled on rising clk)
//   bus     slave side of hazard_stall_unit_if:
//           ID/EX/MEM hazard status in; pcWrite, ifidWrite, ifidFlush,
//           idexBubble, stallActive, stallCycles out
// Stall decisions are combinational so the first bubble lands in the same
// cycle the hazard is seen; only the remaining length is carried in r_cnt.
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int AddressSize = ADDRESS_SIZE,
    parameter int CntWidth    = 32,
    parameter int MaxStall    = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    hazard_stall_unit_if.slave bus
);

    localparam int StallW = $clog2(MaxStall + 1);

    stall_state_e        r_state;
    stall_state_e        w_next_state;
    logic [StallW-1:0]   r_cnt;
    logic [StallW-1:0]   w_cnt_next;
    logic [StallW-1:0]   w_stall_len;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_stall_active;

    // Hazard decode: required stall length for the instruction now in ID.
    always_comb begin
        w_hit_ex  = (bus.idUsesRs1 && reg_hit(bus.EXRegisterRd,  bus.IDRs1)) ||
                    (bus.idUsesRs2 && reg_hit(bus.EXRegisterRd,  bus.IDRs2));
        w_hit_mem = (bus.idUsesRs1 && reg_hit(bus.MemRegisterRd, bus.IDRs1)) ||
                    (bus.idUsesRs2 && reg_hit(bus.MemRegisterRd, bus.IDRs2));
        w_stall_len = StallW'(0);
        if (bus.idIsBranch) begin
            // A load in EX outranks every other branch rule, so check it first.
            if (bus.regWriteEX && bus.memReadEX && w_hit_ex) begin
                w_stall_len = StallW'(2);
            end else if (bus.regWriteEX && w_hit_ex) begin
                w_stall_len = StallW'(1);
            end else if (bus.memReadMem && w_hit_mem) begin
                w_stall_len = StallW'(1);
            end else begin
                w_stall_len = StallW'(0);
            end
        end else begin
            // Non-branch consumers get everything else from the bypass network.
            if (bus.memReadEX && w_hit_ex) begin
                w_stall_len = StallW'(1);
            end else begin
                w_stall_len = StallW'(0);
            end
        end
    end

    // FSM next state, remaining-length counter and pipeline controls.
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_stall_active = 1'b0;
        if (arst_n) begin
            case (r_state)
                RUN: begin
                    if (w_stall_len != StallW'(0)) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_cnt_next    = w_stall_len - StallW'(1);
                        if (w_stall_len > StallW'(1)) begin
                            w_next_state = STALL;
                        end else begin
                            w_next_state = RUN;
                        end
                    end else begin
                        // Only a branch with all operands ready may redirect fetch.
                        w_ifid_flush = bus.idIsBranch && bus.branchTaken;
                        w_cnt_next   = StallW'(0);
                        w_next_state = RUN;
                    end
                end
                STALL: begin
                    w_pc_write     = 1'b0;
                    w_ifid_write   = 1'b0;
                    w_idex_bubble  = 1'b1;
                    w_stall_active = 1'b1;
                    if (r_cnt != StallW'(0)) begin
                        w_cnt_next = r_cnt - StallW'(1);
                    end else begin
                        w_cnt_next = StallW'(0);
                    end
                    // Leave once the count reaches zero at this edge.
                    if (r_cnt <= StallW'(1)) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_state = STALL;
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_cnt_next   = StallW'(0);
                end
            endcase
        end else begin
            // Reset cycle: let the pipeline run and drop any stall in progress.
            w_next_state = RUN;
            w_cnt_next   = StallW'(0);
        end
    end

    // State and remaining-length registers.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= RUN;
            r_cnt   <= StallW'(0);
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    stall_perf_counter #(
        .CntWidth (CntWidth)
    ) u_perf (
        .clk     (clk),
        .i_clr_n (arst_n),
        .i_inc   (w_idex_bubble),
        .o_count (bus.stallCycles)
    );

    assign bus.pcWrite     = w_pc_write;
    assign bus.ifidWrite   = w_ifid_write;
    assign bus.ifidFlush   = w_ifid_flush;
    assign bus.idexBubble  = w_idex_bubble;
    assign bus.stallActive = w_stall_active;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed and random stimulus for hazard_stall_unit. A second instance with a
// 2-bit performance counter exercises counter saturation in a few cycles.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic arst_n;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.AddressSize(5), .CntWidth(32)) bus_main ();
    hazard_stall_unit_if #(.AddressSize(5), .CntWidth(2))  bus_sat ();

    logic [4:0] t_rs1, t_rs2, t_exrd, t_memrd;
    logic       t_u1, t_u2, t_br, t_tk, t_rwex, t_mrex, t_mrmem;

    assign bus_main.IDRs1 = t_rs1;         assign bus_sat.IDRs1 = t_rs1;
    assign bus_main.IDRs2 = t_rs2;         assign bus_sat.IDRs2 = t_rs2;
    assign bus_main.idUsesRs1 = t_u1;      assign bus_sat.idUsesRs1 = t_u1;
    assign bus_main.idUsesRs2 = t_u2;      assign bus_sat.idUsesRs2 = t_u2;
    assign bus_main.idIsBranch = t_br;     assign bus_sat.idIsBranch = t_br;
    assign bus_main.branchTaken = t_tk;    assign bus_sat.branchTaken = t_tk;
    assign bus_main.EXRegisterRd = t_exrd; assign bus_sat.EXRegisterRd = t_exrd;
    assign bus_main.regWriteEX = t_rwex;   assign bus_sat.regWriteEX = t_rwex;
    assign bus_main.memReadEX = t_mrex;    assign bus_sat.memReadEX = t_mrex;
    assign bus_main.MemRegisterRd = t_memrd; assign bus_sat.MemRegisterRd = t_memrd;
    assign bus_main.memReadMem = t_mrmem;  assign bus_sat.memReadMem = t_mrmem;

    hazard_stall_unit #(.AddressSize(5), .CntWidth(32), .MaxStall(2)) u_dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_main)
    );

    hazard_stall_unit #(.AddressSize(5), .CntWidth(2), .MaxStall(2)) u_sat (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_sat)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: stall cycles still owed, and bubble counts.
    int      m_pending = 0;
    longint  m_cnt     = 0;
    int      m_cnt_sat = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles the instruction in ID must wait, taken as the maximum over the hazard rules.
    function automatic int req_stall(input bit br, input bit u1, input bit u2,
                                     input int rs1, input int rs2, input int exrd,
                                     input bit rwex, input bit mrex, input int memrd,
                                     input bit mrmem);
        bit ex_hit, mem_hit;
        int n;
        ex_hit  = (exrd != 0) && ((u1 && exrd == rs1) || (u2 && exrd == rs2));
        mem_hit = (memrd != 0) && ((u1 && memrd == rs1) || (u2 && memrd == rs2));
        n = 0;
        if (br && mrex && rwex && ex_hit && n < 2) n = 2;
        if (br && rwex && !mrex && ex_hit && n < 1) n = 1;
        if (br && mrmem && mem_hit && n < 1) n = 1;
        if (!br && mrex && ex_hit && n < 1) n = 1;
        return n;
    endfunction

    // One clock cycle: drive at negedge, check mid-low-phase, then advance the model.
    task automatic step(input bit rst_n, input bit br, input bit tk, input bit u1, input bit u2,
                        input int rs1, input int rs2, input int exrd, input bit rwex,
                        input bit mrex, input int memrd, input bit mrmem);
        int n;
        bit e_pc, e_flush, e_bub, e_act;
        int next_pending;
        @(negedge clk);
        arst_n = rst_n;
        t_br = br; t_tk = tk; t_u1 = u1; t_u2 = u2;
        t_rs1 = 5'(rs1); t_rs2 = 5'(rs2); t_exrd = 5'(exrd); t_rwex = rwex;
        t_mrex = mrex; t_memrd = 5'(memrd); t_mrmem = mrmem;
        #2;
        e_pc = 1'b1; e_flush = 1'b0; e_bub = 1'b0; e_act = 1'b0; next_pending = 0;
        if (!rst_n) begin
            next_pending = 0;
        end else if (m_pending > 0) begin
            e_pc = 1'b0; e_bub = 1'b1; e_act = 1'b1;
            next_pending = m_pending - 1;
        end else begin
            n = req_stall(br, u1, u2, rs1, rs2, exrd, rwex, mrex, memrd, mrmem);
            if (n > 0) begin
                e_pc = 1'b0; e_bub = 1'b1;
                next_pending = n - 1;
            end else begin
                e_flush = br && tk;
            end
        end
        check("pcWrite",     64'(bus_main.pcWrite),     64'(e_pc));
        check("ifidWrite",   64'(bus_main.ifidWrite),   64'(e_pc));
        check("ifidFlush",   64'(bus_main.ifidFlush),   64'(e_flush));
        check("idexBubble",  64'(bus_main.idexBubble),  64'(e_bub));
        check("stallActive", 64'(bus_main.stallActive), 64'(e_act));
        check("stallCycles", 64'(bus_main.stallCycles), 64'(m_cnt));
        check("satCycles",   64'(bus_sat.stallCycles),  64'(m_cnt_sat));
        check("satBubble",   64'(bus_sat.idexBubble),   64'(e_bub));
        if (!rst_n) begin
            m_cnt = 0; m_cnt_sat = 0; m_pending = 0;
        end else begin
            if (e_bub) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt_sat < 3) m_cnt_sat = m_cnt_sat + 1;
            end
            m_pending = next_pending;
        end
    endtask

    task automatic idle(input bit rst_n);
        step(rst_n, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        arst_n = 1'b0;
        t_rs1 = 5'd0; t_rs2 = 5'd0; t_exrd = 5'd0; t_memrd = 5'd0;
        t_u1 = 1'b0; t_u2 = 1'b0; t_br = 1'b0; t_tk = 1'b0;
        t_rwex = 1'b0; t_mrex = 1'b0; t_mrmem = 1'b0;

        // Reset state.
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // Load x5 in EX, add uses x5: one bubble, then the load has moved to MEM.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5, 6, 5, 1'b1, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5, 6, 0, 1'b0, 1'b0, 5, 1'b1);
        @(posedge clk); #1;
        check("loaduse_count", 64'(bus_main.stallCycles), 64'd1);

        // Load x7 in EX, beq x7,x1 taken: two stalls, then flush when resolved.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7, 1, 7, 1'b1, 1'b1, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7, 1, 0, 1'b0, 1'b0, 7, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7, 1, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(1'b1);

        // ALU writes x3 in EX, bne x3,x0 taken: one stall and no flush while stalled.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 3, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 0, 1'b0, 1'b0, 3, 1'b0);
        // Same shape with rd=x0: never a hazard, the taken branch flushes at once.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0);

        // Load x9 in EX, store with data rs2=x9 (not an operand use): no stall.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 9, 9, 1'b1, 1'b1, 0, 1'b0);
        idle(1'b1);

        // Reset in the second cycle of a two-cycle stall.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7, 1, 7, 1'b1, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7, 1, 0, 1'b0, 1'b0, 7, 1'b1);
        idle(1'b1);
        check("rst_abort_pc",    64'(bus_main.pcWrite),     64'd1);
        check("rst_abort_count", 64'(bus_main.stallCycles), 64'd0);

        // Saturation on the narrow counter: 2 + 2 bubbles saturate a 2-bit count at 3.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 4, 1'b1, 1'b1, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, 4, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 4, 1'b1, 1'b1, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, 4, 1'b1);
        idle(1'b1);
        check("sat_hold", 64'(bus_sat.stallCycles), 64'd3);
        check("sat_main", 64'(bus_main.stallCycles), 64'd4);

        // Random traffic over a small register range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
